// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: defaults, state encoding
// and the IM write-port payload.
package imem_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned IMEM_DEPTH_DEF = 256;
    localparam int unsigned CNT_W_DEF      = 16;

    localparam logic [ADDR_W-1:0] BASE_ADDR_DEF = 32'h0000_0000;
    // The core's PC comes out of reset at the first loaded word.
    localparam logic [ADDR_W-1:0] PC_RESET      = BASE_ADDR_DEF;

    typedef enum logic [2:0] {
        LDR_IDLE  = 3'd0,
        LDR_HDR   = 3'd1,
        LDR_DATA  = 3'd2,
        LDR_WRITE = 3'd3,
        LDR_DONE  = 3'd4,
        LDR_ERR   = 3'd5
    } ldr_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } im_wr_t;

    // Byte address of word idx; wraps modulo 2^32.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects four stream bytes into a little-endian 32-bit word; shared by the
// header and data phases of the loader.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_c,
    output logic              word_full_c
);

    logic [1:0]        cnt_q;
    logic [WORD_W-1:0] word_q;

    // Newest byte enters at the top so the first byte ends up in [7:0].
    assign word_c      = {byte_in, word_q[WORD_W-1:BYTE_W]};
    assign word_full_c = shift_en && (cnt_q == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= 2'd0;
            word_q <= '0;
        end else if (clear) begin
            cnt_q  <= 2'd0;
            word_q <= '0;
        end else if (shift_en) begin
            cnt_q  <= cnt_q + 2'd1;
            word_q <= word_c;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into the instruction memory write
// port while holding the CPU fetch path.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned       IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = BASE_ADDR_DEF,
    parameter int unsigned       CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              IM_we,
    output logic [ADDR_W-1:0] IM_wr_addr,
    output logic [WORD_W-1:0] IM_wr_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [CNT_W-1:0]  words_loaded
);

    ldr_state_e        state_q;
    ldr_state_e        state_d;
    logic [WORD_W-1:0] n_words_q;
    logic [CNT_W-1:0]  idx_q;
    im_wr_t            wr_q;

    logic              pk_shift_c;
    logic              pk_clear_c;
    logic              pk_full_c;
    logic [WORD_W-1:0] pk_word_c;
    logic              hdr_last_c;
    logic              data_last_c;
    logic              word_last_c;
    logic              n_zero_c;
    logic              n_over_c;

    // Ready depends on state alone so the source never sees a combinational loop.
    assign byte_ready = (state_q == LDR_HDR) || (state_q == LDR_DATA);
    assign pk_shift_c = byte_valid && byte_ready;

    imem_loader_byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear       (pk_clear_c),
        .shift_en    (pk_shift_c),
        .byte_in     (byte_data),
        .word_c      (pk_word_c),
        .word_full_c (pk_full_c)
    );

    assign hdr_last_c  = (state_q == LDR_HDR)  && pk_full_c;
    assign data_last_c = (state_q == LDR_DATA) && pk_full_c;
    assign n_zero_c    = (pk_word_c == '0);
    assign n_over_c    = (pk_word_c > 32'(IMEM_DEPTH));
    assign word_last_c = ((32'(idx_q) + 32'd1) == n_words_q);

    // Next-state decode.
    always_comb begin
        state_d    = state_q;
        pk_clear_c = 1'b0;
        unique case (state_q)
            LDR_IDLE: begin
                if (start) begin
                    state_d    = LDR_HDR;
                    pk_clear_c = 1'b1;
                end
            end
            LDR_HDR: begin
                if (hdr_last_c) begin
                    if (n_zero_c)      state_d = LDR_DONE;
                    else if (n_over_c) state_d = LDR_ERR;
                    else               state_d = LDR_DATA;
                end
            end
            LDR_DATA: begin
                if (data_last_c) state_d = LDR_WRITE;
            end
            LDR_WRITE: begin
                state_d = word_last_c ? LDR_DONE : LDR_DATA;
            end
            LDR_DONE: begin
                state_d = LDR_IDLE;
            end
            LDR_ERR: begin
                if (start) begin
                    state_d    = LDR_HDR;
                    pk_clear_c = 1'b1;
                end
            end
            default: begin
                state_d = LDR_IDLE;
            end
        endcase
    end

    // State and status flags, registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= LDR_IDLE;
            IM_we     <= 1'b0;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            IM_we     <= (state_d == LDR_WRITE);
            cpu_hold  <= (state_d != LDR_IDLE);
            load_done <= (state_d == LDR_DONE);
            load_err  <= (state_d == LDR_ERR);
        end
    end

    // Header length, word index and the IM write payload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_words_q <= '0;
            idx_q     <= '0;
            wr_q      <= '0;
        end else begin
            if (hdr_last_c) begin
                n_words_q <= pk_word_c;
            end
            if (data_last_c) begin
                wr_q.addr <= word_addr(BASE_ADDR, 32'(idx_q));
                wr_q.data <= pk_word_c;
            end
            if (pk_clear_c) begin
                idx_q <= '0;
            end else if (state_q == LDR_WRITE) begin
                idx_q <= idx_q + CNT_W'(1);
            end
        end
    end

    assign IM_wr_addr   = wr_q.addr;
    assign IM_wr_data   = wr_q.data;
    assign words_loaded = idx_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a queue-based image model checked every cycle,
// plus literal expectations for each scenario.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        IM_we;
    logic [31:0] IM_wr_addr;
    logic [31:0] IM_wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_loaded;

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .IM_we        (IM_we),
        .IM_wr_addr   (IM_wr_addr),
        .IM_wr_data   (IM_wr_data),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  stim_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] exp_n;
    bit          got_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare against the image model.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("byte_ready_rule", 32'(byte_ready),
                  32'(cpu_hold & ~IM_we & ~load_done & ~load_err));
            if (IM_we === 1'b1) begin
                check("write_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) begin
                    check("wr_addr", IM_wr_addr, exp_addr_q.pop_front());
                    check("wr_data", IM_wr_data, exp_data_q.pop_front());
                end
                check("hold_in_write", 32'(cpu_hold), 32'd1);
                log_addr.push_back(IM_wr_addr);
                log_data.push_back(IM_wr_data);
            end
        end
    end

    // Derive the expected IM writes straight from the byte image.
    task automatic plan();
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_n = {stim_q[3], stim_q[2], stim_q[1], stim_q[0]};
        if (exp_n != 0 && exp_n <= 256) begin
            for (int i = 0; i < int'(exp_n); i++) begin
                exp_addr_q.push_back(32'(i * 4));
                exp_data_q.push_back({stim_q[4+4*i+3], stim_q[4+4*i+2],
                                      stim_q[4+4*i+1], stim_q[4+4*i]});
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int budget = 0;
        if (rnd) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("byte_accept", 32'(byte_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic run_load(input bit rnd, input int start_at, output bit err);
        int budget = 0;
        log_addr.delete();
        log_data.delete();
        plan();
        pulse_start();
        foreach (stim_q[i]) begin
            if (i == start_at) pulse_start();
            send_byte(stim_q[i], rnd);
        end
        while (load_done !== 1'b1 && load_err !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("load_finished", 32'(load_done | load_err), 32'd1);
        err = load_err;
        if (load_done === 1'b1) begin
            check("queue_drained", 32'(exp_addr_q.size()), 32'd0);
            check("words_loaded", 32'(words_loaded), exp_n);
            @(negedge clk);
            check("done_pulse_len", 32'(load_done), 32'd0);
            check("hold_released", 32'(cpu_hold), 32'd0);
        end else begin
            check("err_expected", 32'(exp_n > 256), 32'd1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    32'(IM_we), 32'd0);
        check({tag, "_addr"},  IM_wr_addr, 32'd0);
        check({tag, "_data"},  IM_wr_data, 32'd0);
        check({tag, "_hold"},  32'(cpu_hold), 32'd0);
        check({tag, "_done"},  32'(load_done), 32'd0);
        check({tag, "_err"},   32'(load_err), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    endtask

    task automatic check_two_word_log(input string tag, input logic [31:0] d0, input logic [31:0] d1);
        check({tag, "_nwrites"}, 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            check({tag, "_addr0"}, log_addr[0], 32'h0000_0000);
            check({tag, "_data0"}, log_data[0], d0);
            check({tag, "_addr1"}, log_addr[1], 32'h0000_0004);
            check({tag, "_data1"}, log_data[1], d1);
        end
    endtask

    initial begin
        int we_seen;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Test 1: async reset in DATA with two bytes taken
        pulse_start();
        stim_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        foreach (stim_q[i]) send_byte(stim_q[i], 1'b0);
        check("t1_hold_before", 32'(cpu_hold), 32'd1);
        #2 rst = 1'b0;
        #1 check_all_zero("t1_async");
        @(negedge clk);
        rst = 1'b1;
        we_seen = 0;
        byte_valid = 1'b1;
        byte_data  = 8'hCC;
        repeat (12) begin
            @(negedge clk);
            if (IM_we === 1'b1) we_seen++;
        end
        byte_valid = 1'b0;
        check("t1_no_write", 32'(we_seen), 32'd0);
        check("t1_idle_hold", 32'(cpu_hold), 32'd0);

        // Test 2: normal two-word load
        stim_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00};
        run_load(1'b0, -1, got_err);
        check("t2_no_err", 32'(got_err), 32'd0);
        check_two_word_log("t2", 32'h0000_0013, 32'h0010_0093);

        // Test 3: empty image
        stim_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_load(1'b0, -1, got_err);
        check("t3_nwrites", 32'(log_addr.size()), 32'd0);
        check("t3_words", 32'(words_loaded), 32'd0);

        // Test 4: oversize header, then recovery
        stim_q = '{8'h01, 8'h01, 8'h00, 8'h00};
        run_load(1'b0, -1, got_err);
        check("t4_err", 32'(got_err), 32'd1);
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (3) begin
            @(negedge clk);
            check("t4_err_ready", 32'(byte_ready), 32'd0);
            check("t4_err_hold", 32'(cpu_hold), 32'd1);
            check("t4_err_sticky", 32'(load_err), 32'd1);
        end
        byte_valid = 1'b0;
        stim_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        run_load(1'b0, -1, got_err);
        check("t4_err_cleared", 32'(load_err), 32'd0);
        check("t4_nwrites", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) begin
            check("t4_addr0", log_addr[0], 32'h0000_0000);
            check("t4_data0", log_data[0], 32'h1234_5678);
        end

        // Test 5: random gaps in byte_valid
        stim_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00};
        run_load(1'b1, -1, got_err);
        check_two_word_log("t5", 32'h0000_0013, 32'h0010_0093);

        // Test 6: start pulse mid-DATA is ignored
        stim_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                   8'h11, 8'h22, 8'h33, 8'h44};
        run_load(1'b0, 6, got_err);
        check_two_word_log("t6", 32'hDDCC_BBAA, 32'h4433_2211);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
